fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding a shared write FIFO
// Grants one requester per burst; the FIFO read side is a plain combinational pass-through.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_push,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  output logic                          fifo_pop,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic                          gnt_valid,
  output logic [2:0]                    gnt_id,
  output logic                          err_burst,
  input  logic                          err_clr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  push;
  logic                  found_hi;
  logic [IW-1:0]         pick_hi;
  logic [IW-1:0]         pick_lo;
  logic [IW-1:0]         pick;
  logic                  err_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Round-robin pick: lowest valid index above last_q, else lowest valid overall.
  always_comb begin
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_lo = IW'(i);
        if (IW'(i) > last_q) begin
          pick_hi  = IW'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == IW'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = (state_q == LOCK) && !fifo_full;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = LOCK;
          gnt_d   = pick;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        push = sel_valid && !fifo_full;
        if (push) begin
          cnt_d = cnt_q + 1'b1;
          if (sel_last) begin
            state_d = IDLE;
            last_d  = gnt_q;
          end else if (cnt_q == CW'(MAX_BEATS - 1)) begin
            state_d = IDLE;
            last_d  = gnt_q;
            err_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new overrun takes priority over a clear in the same cycle.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  assign fifo_push = push;
  assign fifo_din  = sel_data;
  assign gnt_valid = (state_q == LOCK);
  assign gnt_id    = 3'(gnt_q);
  assign err_burst = err_q;

  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_dout;
  assign fifo_pop  = m_valid && m_ready;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
// Inputs change 1 ns after each rising edge; outputs are checked 1 ns later.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  fifo_din;
  logic        fifo_push;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        fifo_pop;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic        gnt_valid;
  logic [2:0]  gnt_id;
  logic        err_burst;
  logic        err_clr;

  int n_assert = 0;
  int n_fail   = 0;
  int pops     = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BEATS(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_din(fifo_din), .fifo_push(fifo_push), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .err_burst(err_burst), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout = '0;
    m_ready   = 1'b0;
    err_clr   = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    int order040[5];
    int order039[4];
    order040 = '{0, 1, 2, 3, 0};
    order039 = '{1, 3, 1, 3};
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset values while resetn is low
    resetn = 1'b0; req_valid = 4'b1111; req_last = '0; fifo_full = 1'b0;
    fifo_empty = 1'b1; fifo_dout = '0; m_ready = 1'b0; err_clr = 1'b0;
    #2;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_push", fifo_push, 1'b0);
    chk("rst_gnt_valid", gnt_valid, 1'b0);
    chk("rst_gnt_id", gnt_id, 3'd0);
    chk("rst_err", err_burst, 1'b0);
    cyc();
    chk("rst_held_gnt_valid", gnt_valid, 1'b0);

    // All four requesters, single-beat bursts: order 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr4_idle", gnt_valid, 1'b0);
      chk("rr4_idle_push", fifo_push, 1'b0);
      cyc();
      #1;
      chk("rr4_gnt_id", gnt_id, order040[k]);
      chk("rr4_push", fifo_push, 1'b1);
      chk("rr4_din", fifo_din, 8'hA0 + order040[k]);
      chk("rr4_ready", req_ready, 4'b0001 << order040[k]);
      cyc();
    end
    chk("rr4_gnt_id_hold_idle", gnt_id, 3'd0);

    // req_valid=1010, 2-beat bursts: grants 1,3,1,3 with one idle cycle between
    do_reset();
    req_valid = 4'b1010; req_last = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      req_last = 4'b0000;
      #1;
      chk("alt_idle", gnt_valid, 1'b0);
      cyc();
      #1;
      chk("alt_gnt_valid", gnt_valid, 1'b1);
      chk("alt_gnt_id", gnt_id, order039[k]);
      chk("alt_beat0_push", fifo_push, 1'b1);
      cyc();
      req_last = 4'b1111;
      #1;
      chk("alt_beat1_push", fifo_push, 1'b1);
      chk("alt_beat1_gnt_id", gnt_id, order039[k]);
      cyc();
    end
    req_last = 4'b0000;

    // Requester 2, fifo_full stall of 3 cycles mid-burst
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0000;
    req_data = {8'hA3, 8'h50, 8'hA1, 8'hA0};
    cyc();
    #1;
    chk("full_beat0_push", fifo_push, 1'b1);
    chk("full_beat0_din", fifo_din, 8'h50);
    cyc();
    req_data = {8'hA3, 8'h51, 8'hA1, 8'hA0};
    #1;
    chk("full_beat1_push", fifo_push, 1'b1);
    chk("full_beat1_din", fifo_din, 8'h51);
    cyc();
    req_data = {8'hA3, 8'h52, 8'hA1, 8'hA0};
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_stall_ready", req_ready, 4'b0000);
      chk("full_stall_push", fifo_push, 1'b0);
      chk("full_stall_gnt_id", gnt_id, 3'd2);
      chk("full_stall_gnt_valid", gnt_valid, 1'b1);
      cyc();
    end
    fifo_full = 1'b0;
    #1;
    chk("full_resume_ready", req_ready, 4'b0100);
    chk("full_resume_push", fifo_push, 1'b1);
    chk("full_resume_din", fifo_din, 8'h52);
    cyc();
    req_data = {8'hA3, 8'h53, 8'hA1, 8'hA0};
    req_last = 4'b0100;
    #1;
    chk("full_last_push", fifo_push, 1'b1);
    chk("full_last_din", fifo_din, 8'h53);
    cyc();
    req_valid = 4'b0000; req_last = 4'b0000;
    #1;
    chk("full_done_idle", gnt_valid, 1'b0);

    // 16 beats with no req_last: overrun ends the burst and sets err_burst
    do_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b0001; req_last = 4'b0000;
    cyc();
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("ovr_push", fifo_push, 1'b1);
      chk("ovr_gnt_valid", gnt_valid, 1'b1);
      if (k == 16) chk("ovr_err_before", err_burst, 1'b0);
      cyc();
    end
    req_valid = 4'b0000;
    #1;
    chk("ovr_idle", gnt_valid, 1'b0);
    chk("ovr_push_after", fifo_push, 1'b0);
    chk("ovr_err_set", err_burst, 1'b1);
    cyc();
    #1;
    chk("ovr_err_sticky", err_burst, 1'b1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #1;
    chk("ovr_err_cleared", err_burst, 1'b0);

    // Reset during beat 3 abandons the burst
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0000;
    cyc();
    cyc();
    cyc();
    #1;
    chk("rstmid_beat3_push", fifo_push, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rstmid_ready", req_ready, 4'b0000);
    chk("rstmid_push", fifo_push, 1'b0);
    chk("rstmid_gnt_valid", gnt_valid, 1'b0);
    cyc();
    #1;
    chk("rstmid_held_push", fifo_push, 1'b0);
    resetn = 1'b1;
    #1;
    chk("rstmid_release_push", fifo_push, 1'b0);
    chk("rstmid_release_idle", gnt_valid, 1'b0);
    cyc();
    #1;
    chk("rstmid_regrant_push", fifo_push, 1'b1);

    // Consumer side: head 0x11 then 0x22, concurrent with a push
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0001;
    cyc();
    fifo_empty = 1'b0; fifo_dout = 8'h11; m_ready = 1'b1;
    #1;
    chk("cons_valid0", m_valid, 1'b1);
    chk("cons_data0", m_data, 8'h11);
    chk("cons_push_same_cycle", fifo_push, 1'b1);
    if (fifo_pop) pops++;
    cyc();
    req_valid = 4'b0000;
    fifo_dout = 8'h22;
    #1;
    chk("cons_data1", m_data, 8'h22);
    if (fifo_pop) pops++;
    cyc();
    fifo_empty = 1'b1;
    #1;
    chk("cons_valid_empty", m_valid, 1'b0);
    if (fifo_pop) pops++;
    chk("cons_pop_count", pops, 2);
    fifo_empty = 1'b0; m_ready = 1'b0;
    #1;
    chk("cons_no_ready_pop", fifo_pop, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
